// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;

    typedef enum logic {MEM_IDLE, MEM_WAIT} memfsm_t;

    // EX operand select encodings
    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

    // Source/destination match; register 0 is hardwired and never a hazard.
    function automatic logic reg_hit(input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory handshake tracker: holds the pipe while dmem is busy and
// abandons the access after MEM_TIMEOUT wait cycles.
// Ports:
//   clk, reset      clock, async active-high reset
//   memacc          load or store present in MEM
//   dmem_ready      memory completes the access this cycle
//   dmem_req        request to data memory (forced low while reset is high)
//   memstall        hold the whole pipe this cycle
//   mem_err         sticky timeout flag, cleared only by reset
module mem_wait_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic memacc,
    input  logic dmem_ready,
    output logic dmem_req,
    output logic memstall,
    output logic mem_err
);

    localparam int unsigned TIMER_W = $clog2(MEM_TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(MEM_TIMEOUT - 1);

    memfsm_t            state, state_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic               req_raw, stall_raw, err_set;

    // State, timer and sticky error registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= MEM_IDLE;
            timer   <= '0;
            mem_err <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            if (err_set) begin
                mem_err <= 1'b1;
            end
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        req_raw   = 1'b0;
        stall_raw = 1'b0;
        err_set   = 1'b0;
        case (state)
            MEM_IDLE: begin
                req_raw   = memacc;
                timer_nxt = '0;
                // Ready in the same cycle is a zero-wait access
                if (memacc && !dmem_ready) begin
                    state_nxt = MEM_WAIT;
                    stall_raw = 1'b1;
                end
            end
            MEM_WAIT: begin
                req_raw = 1'b1;
                if (dmem_ready) begin
                    state_nxt = MEM_IDLE;
                    timer_nxt = '0;
                end else if (timer == TIMER_LAST) begin
                    // Give up: release the pipe, the load data is undefined
                    state_nxt = MEM_IDLE;
                    timer_nxt = '0;
                    err_set   = 1'b1;
                end else begin
                    stall_raw = 1'b1;
                    timer_nxt = timer + TIMER_W'(1);
                end
            end
            default: state_nxt = MEM_IDLE;
        endcase
    end

    // Request and stall drop asynchronously with reset
    assign dmem_req = req_raw & ~reset;
    assign memstall = stall_raw & ~reset;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: forwarding selects,
// load-use / branch stalls, branch/jump flush, dmem wait hold and
// saturating perf counters.
// Ports:
//   clk, reset                       clock, async active-high reset
//   rsD/rtD, rsE/rtE                 source registers in ID / EX
//   writeregE/M/W, regwriteE/M/W     destination and write enable per stage
//   memtoregE/M, memwriteM           load in EX/MEM, store in MEM
//   branchD, pcsrcD, jumpD           branch in ID, taken branch, jump
//   dmem_ready, dmem_req             data memory handshake
//   stallF/D/E/M, flushD/E/W         stage register hold / clear
//   forwardAD/BD, forwardAE/BE       forwarding selects for ID and EX
//   mem_err                          sticky dmem timeout flag
//   stall_cnt, flush_cnt             saturating perf counters
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] writeregE,
    input  logic [REG_W-1:0] writeregM,
    input  logic [REG_W-1:0] writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             memwriteM,
    input  logic             branchD,
    input  logic             pcsrcD,
    input  logic             jumpD,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic [FWD_W-1:0] forwardAE,
    output logic [FWD_W-1:0] forwardBE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic memstall, lwstall, brstall, hzstall;

    mem_wait_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait (
        .clk        (clk),
        .reset      (reset),
        .memacc     (memtoregM | memwriteM),
        .dmem_ready (dmem_ready),
        .dmem_req   (dmem_req),
        .memstall   (memstall),
        .mem_err    (mem_err)
    );

    // Forwarding selects; MEM beats WB
    always_comb begin
        forwardAE = FWD_RF;
        forwardBE = FWD_RF;
        if (regwriteM && reg_hit(rsE, writeregM))      forwardAE = FWD_MEM;
        else if (regwriteW && reg_hit(rsE, writeregW)) forwardAE = FWD_WB;
        if (regwriteM && reg_hit(rtE, writeregM))      forwardBE = FWD_MEM;
        else if (regwriteW && reg_hit(rtE, writeregW)) forwardBE = FWD_WB;
        forwardAD = regwriteM && reg_hit(rsD, writeregM);
        forwardBD = regwriteM && reg_hit(rtD, writeregM);
    end

    // Load-use and branch-operand stalls
    always_comb begin
        lwstall = memtoregE && (reg_hit(rsD, rtE) || reg_hit(rtD, rtE));
        brstall = branchD &&
                  ((regwriteE && (reg_hit(rsD, writeregE) || reg_hit(rtD, writeregE))) ||
                   (memtoregM && (reg_hit(rsD, writeregM) || reg_hit(rtD, writeregM))));
        hzstall = lwstall | brstall;
    end

    // Stall/flush priority: memory hold, then hazard stall, then redirect
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushW = 1'b0;
        if (memstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (hzstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end else if (pcsrcD || jumpD) begin
            flushD = 1'b1;
        end
    end

    // Saturating perf counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((stallF | stallD | stallE | stallM) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if ((flushD | flushE) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic             regwriteE, regwriteM, regwriteW;
    logic             memtoregE, memtoregM, memwriteM;
    logic             branchD, pcsrcD, jumpD, dmem_ready;
    logic             dmem_req, stallF, stallD, stallE, stallM;
    logic             flushD, flushE, flushW, forwardAD, forwardBD, mem_err;
    logic [1:0]       forwardAE, forwardBE;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int ncmp = 0;
    int nerr = 0;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM), .memwriteM(memwriteM),
        .branchD(branchD), .pcsrcD(pcsrcD), .jumpD(jumpD),
        .dmem_ready(dmem_ready), .dmem_req(dmem_req),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {stallF,stallD,stallE,stallM,flushD,flushE,flushW}
    function automatic logic [31:0] ctl();
        return 32'({stallF, stallD, stallE, stallM, flushD, flushE, flushW});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoregE = 0; memtoregM = 0; memwriteM = 0;
        branchD = 0; pcsrcD = 0; jumpD = 0; dmem_ready = 0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        tick(); tick();
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_err", 32'(mem_err), 0);
        chk("rst_scnt", 32'(stall_cnt), 0);
        chk("rst_fcnt", 32'(flush_cnt), 0);
        chk("rst_ctl", ctl(), 0);
        reset = 1'b0;
        tick();

        // Forwarding (combinational, no stall)
        rsE = 5'd3; writeregM = 5'd3; regwriteM = 1; writeregW = 5'd3; regwriteW = 1;
        #1 chk("fwdAE_mem", 32'(forwardAE), 32'b10);
        regwriteM = 0;
        #1 chk("fwdAE_wb", 32'(forwardAE), 32'b01);
        rtE = 5'd3; regwriteM = 1;
        #1 chk("fwdBE_mem", 32'(forwardBE), 32'b10);
        rsE = 5'd0; writeregM = 5'd0; writeregW = 5'd0;
        #1 chk("fwdAE_r0", 32'(forwardAE), 32'b00);
        rsD = 5'd9; rtD = 5'd8; writeregM = 5'd9;
        #1 chk("fwdAD", 32'(forwardAD), 1);
        chk("fwdBD", 32'(forwardBD), 0);
        clear_inputs();
        tick();

        // Load-use stall for exactly one cycle
        memtoregE = 1; rtE = 5'd5; rsD = 5'd5;
        #1 chk("lw_ctl", ctl(), 32'b1100010);
        tick();
        rsD = 5'd0; rtE = 5'd0;
        #1 chk("lw_r0_ctl", ctl(), 0);

        // Stall beats taken branch, then branch alone flushes ID
        rtE = 5'd5; rsD = 5'd5; pcsrcD = 1;
        #1 chk("lw_pc_ctl", ctl(), 32'b1100010);
        tick();
        memtoregE = 0;
        #1 chk("pc_ctl", ctl(), 32'b0000100);
        tick();
        clear_inputs();

        // Branch operand produced in EX; jump must not flush ID
        branchD = 1; regwriteE = 1; writeregE = 5'd7; rtD = 5'd7; jumpD = 1;
        #1 chk("br_ctl", ctl(), 32'b1100010);
        tick();
        clear_inputs();
        #1 chk("scnt_a", 32'(stall_cnt), 3);
        chk("fcnt_a", 32'(flush_cnt), 4);

        // dmem ready low 3 cycles; memstall overrides a load-use stall
        memtoregM = 1; memtoregE = 1; rtE = 5'd5; rsD = 5'd5;
        #1 chk("mw0_req", 32'(dmem_req), 1);
        chk("mw0_ctl", ctl(), 32'b1111001);
        tick();
        memtoregE = 0;
        for (int i = 1; i < 3; i++) begin
            #1 chk($sformatf("mw%0d_req", i), 32'(dmem_req), 1);
            chk($sformatf("mw%0d_ctl", i), ctl(), 32'b1111001);
            tick();
        end
        dmem_ready = 1;
        #1 chk("mw3_req", 32'(dmem_req), 1);
        chk("mw3_ctl", ctl(), 0);
        tick();
        clear_inputs();
        #1 chk("mw_done_req", 32'(dmem_req), 0);
        chk("scnt_b", 32'(stall_cnt), 6);
        chk("fcnt_b", 32'(flush_cnt), 4);

        // Zero-wait access
        memtoregM = 1; dmem_ready = 1;
        #1 chk("zw_req", 32'(dmem_req), 1);
        chk("zw_ctl", ctl(), 0);
        tick();
        clear_inputs();

        // Timeout: 3 WAIT stall cycles + IDLE stall, release on 4th WAIT
        memwriteM = 1;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("to%0d_ctl", i), ctl(), 32'b1111001);
            tick();
        end
        #1 chk("to_rel_ctl", ctl(), 0);
        chk("to_rel_req", 32'(dmem_req), 1);
        chk("to_rel_err", 32'(mem_err), 0);
        tick();
        clear_inputs();
        #1 chk("to_err", 32'(mem_err), 1);
        chk("to_req", 32'(dmem_req), 0);
        chk("scnt_c", 32'(stall_cnt), 10);
        tick(); tick();
        chk("to_err_sticky", 32'(mem_err), 1);

        // Reset during WAIT
        memtoregM = 1;
        tick(); tick();
        chk("wr_req", 32'(dmem_req), 1);
        reset = 1'b1;
        #1 chk("wr_rst_req", 32'(dmem_req), 0);
        chk("wr_rst_ctl", ctl(), 0);
        chk("wr_rst_scnt", 32'(stall_cnt), 0);
        chk("wr_rst_fcnt", 32'(flush_cnt), 0);
        chk("wr_rst_err", 32'(mem_err), 0);
        tick();
        clear_inputs();
        reset = 1'b0;
        tick();

        // Saturation of both counters
        memtoregE = 1; rtE = 5'd4; rtD = 5'd4;
        for (int i = 0; i < 10; i++) tick();
        chk("sat_mid", 32'(stall_cnt), 10);
        for (int i = 0; i < 10; i++) tick();
        chk("sat_scnt", 32'(stall_cnt), 15);
        chk("sat_fcnt", 32'(flush_cnt), 15);
        clear_inputs();
        tick();
        chk("sat_hold", 32'(stall_cnt), 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
